// File: rtl/motor_spi_pkg.sv
// Shared types and default sizing for the SPI motor-board polling logic.
package motor_spi_pkg;

    localparam int DEF_NUM_MOTORS     = 10;
    localparam int DEF_IDX_W          = 4;
    localparam int DEF_TIMEOUT_CYCLES = 5000;
    localparam int DEF_GAP_CYCLES     = 16;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT_DONE,
        GAP
    } sched_state_e;

endpackage

// File: rtl/rr_next_index.sv
// Round-robin finder: first set mask bit above cur_i, wrapping to the lowest set bit.
module rr_next_index #(
    parameter int N     = 10,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     mask_i,
    input  logic [IDX_W-1:0] cur_i,
    output logic [IDX_W-1:0] next_o
);

    logic [IDX_W-1:0] lowest;
    logic [IDX_W-1:0] above;
    logic             found_low;
    logic             found_above;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        lowest      = '0;
        above       = '0;
        found_low   = 1'b0;
        found_above = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mask_i[i] && !found_low) begin
                lowest    = IDX_W'(i);
                found_low = 1'b1;
            end
            if (mask_i[i] && !found_above && (i > int'(cur_i))) begin
                above       = IDX_W'(i);
                found_above = 1'b1;
            end
        end
        next_o = found_above ? above : lowest;
    end

endmodule

// File: rtl/spi_motor_scheduler.sv
// Round-robin sequencer that shares one SPI master across several motor boards,
// routing slave select, bounding each transaction and spacing them with a gap.
module spi_motor_scheduler
    import motor_spi_pkg::*;
#(
    parameter int NUM_MOTORS     = DEF_NUM_MOTORS,
    parameter int IDX_W          = DEF_IDX_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [NUM_MOTORS-1:0] motor_mask,
    input  logic                  spi_done,
    input  logic                  ss_n,
    input  logic                  clear_flags,
    output logic                  spi_start,
    output logic [NUM_MOTORS-1:0] ss_n_o,
    output logic [IDX_W-1:0]      motor_index,
    output logic                  busy,
    output logic                  cycle_done,
    output logic                  timeout_err,
    output logic [NUM_MOTORS-1:0] timeout_flags
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    sched_state_e          state_q, state_d;
    logic [IDX_W-1:0]      motor_index_q, motor_index_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [NUM_MOTORS-1:0] flags_q, flags_d;
    logic                  spi_done_prev_q;

    logic [IDX_W-1:0]      next_idx;
    logic [IDX_W-1:0]      top_idx;
    logic                  done_evt;
    logic                  run_ok;
    logic                  tmo_hit;
    logic                  sel_active;

    // Completion is the falling edge of the master's done flag.
    assign done_evt   = spi_done_prev_q & ~spi_done;
    assign run_ok     = enable & (|motor_mask);
    assign sel_active = (state_q == START) || (state_q == WAIT_DONE);

    rr_next_index #(
        .N     (NUM_MOTORS),
        .IDX_W (IDX_W)
    ) u_rr_next_index (
        .mask_i (motor_mask),
        .cur_i  (motor_index_q),
        .next_o (next_idx)
    );

    always_comb begin
        top_idx = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (motor_mask[i]) top_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        motor_index_d = motor_index_q;
        tmo_cnt_d     = tmo_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        spi_start     = 1'b0;
        busy          = 1'b0;
        cycle_done    = 1'b0;
        timeout_err   = 1'b0;
        tmo_hit       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run_ok) state_d = SELECT;
            end
            SELECT: begin
                motor_index_d = next_idx;
                state_d       = START;
            end
            START: begin
                spi_start = 1'b1;
                busy      = 1'b1;
                tmo_cnt_d = '0;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                busy      = 1'b1;
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // A completion landing on the timeout cycle still counts as success.
                if (done_evt) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err = 1'b1;
                    tmo_hit     = 1'b1;
                    gap_cnt_d   = '0;
                    state_d     = GAP;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    cycle_done = (|motor_mask) && (motor_index_q == top_idx);
                    state_d    = run_ok ? SELECT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (clear_flags) flags_d = '0;
        if (tmo_hit)     flags_d[motor_index_q] = 1'b1;
    end

    // Selects are decoded from registered state only, so a non-selected board never sees ss_n.
    always_comb begin
        ss_n_o = '1;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (sel_active && (motor_index_q == IDX_W'(i))) ss_n_o[i] = ss_n;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            motor_index_q   <= IDX_W'(NUM_MOTORS - 1);
            tmo_cnt_q       <= '0;
            gap_cnt_q       <= '0;
            flags_q         <= '0;
            spi_done_prev_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            motor_index_q   <= motor_index_d;
            tmo_cnt_q       <= tmo_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            flags_q         <= flags_d;
            spi_done_prev_q <= spi_done;
        end
    end

    assign motor_index   = motor_index_q;
    assign timeout_flags = flags_q;

endmodule
